// File: rtl/plot_scheduler_pkg.sv
// plot_scheduler_pkg: shared graphics constants (screen size, colour width,
// transparent key, sprite size), the scheduler state encoding and a small
// on-screen test used by the pixel pipeline.
package plot_scheduler_pkg;

  localparam int                SCREEN_W_DEF   = 160;
  localparam int                SCREEN_H_DEF   = 120;
  localparam int                SPR_SIZE_DEF   = 16;
  localparam int                SPR_COUNT_DEF  = 4;
  localparam int                COLOUR_W_DEF   = 12;
  localparam logic [11:0]       KEY_COLOUR_DEF = 12'hF0F;

  // Walker coordinates are 8 bits; on-screen sprite coordinates need 9.
  localparam int                COORD_W        = 8;
  localparam int                DRAIN_CYCLES   = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BG_RUN  = 2'd1,
    ST_SPR_RUN = 2'd2,
    ST_DRAIN   = 2'd3
  } state_e;

  // True when a 9-bit coordinate pair lies inside a w x h screen.
  function automatic logic in_screen(input logic [8:0] x, input logic [8:0] y,
                                     input int w, input int h);
    return (int'(x) < w) && (int'(y) < h);
  endfunction

endpackage

// File: rtl/plot_scheduler_pixel_walker.sv
// pixel_walker: loadable width x height row-major coordinate counter.
// 'load' clears the position to (0,0) and captures the extent; 'advance'
// steps one pixel; 'last' flags the final pixel of the current extent.
module pixel_walker
  import plot_scheduler_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [COORD_W-1:0] width,
  input  logic [COORD_W-1:0] height,
  input  logic               advance,
  output logic [COORD_W-1:0] col,
  output logic [COORD_W-1:0] row,
  output logic               last
);

  logic [COORD_W-1:0] col_q, col_d;
  logic [COORD_W-1:0] row_q, row_d;
  logic [COORD_W-1:0] w_q, w_d;
  logic [COORD_W-1:0] h_q, h_d;
  logic               col_end_s;
  logic               row_end_s;

  assign col_end_s = (col_q == (w_q - 8'd1));
  assign row_end_s = (row_q == (h_q - 8'd1));
  assign col       = col_q;
  assign row       = row_q;
  assign last      = col_end_s && row_end_s;

  // Next position: reload on a new blit, otherwise step row-major on advance.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    w_d   = w_q;
    h_d   = h_q;
    if (load) begin
      col_d = 8'd0;
      row_d = 8'd0;
      w_d   = width;
      h_d   = height;
    end else if (advance) begin
      if (col_end_s) begin
        col_d = 8'd0;
        if (row_end_s) begin
          row_d = 8'd0;
        end else begin
          row_d = row_q + 8'd1;
        end
      end else begin
        col_d = col_q + 8'd1;
      end
    end else begin
      col_d = col_q;
    end
  end

  // Walker registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      col_q <= 8'd0;
      row_q <= 8'd0;
      w_q   <= 8'd0;
      h_q   <= 8'd0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      w_q   <= w_d;
      h_q   <= h_d;
    end
  end

endmodule

// File: rtl/plot_scheduler.sv
// plot_scheduler: owns the vga_adapter pixel port and arbitrates between
// full-screen background blits and 16x16 sprite blits (background wins).
// Pipeline: stage 0 ROM address, stage 1 ROM data + delayed coordinates,
// stage 2 registered oX/oY/oColour/oPlot. Off-screen sprite pixels are
// clipped but still take their cycle.
// Build option: define PLOT_SCHED_TRANSPARENCY_EN to suppress sprite pixels
// whose ROM colour equals KEY_COLOUR; without it every on-screen sprite
// pixel is plotted. Background pixels are never keyed.
module plot_scheduler
  import plot_scheduler_pkg::*;
#(
  parameter int                  SCREEN_W   = SCREEN_W_DEF,
  parameter int                  SCREEN_H   = SCREEN_H_DEF,
  parameter int                  SPR_SIZE   = SPR_SIZE_DEF,
  parameter int                  SPR_COUNT  = SPR_COUNT_DEF,
  parameter int                  COLOUR_W   = COLOUR_W_DEF,
  parameter logic [COLOUR_W-1:0] KEY_COLOUR = KEY_COLOUR_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                bg_req,
  output logic                bg_ack,
  input  logic                spr_req,
  input  logic [7:0]          spr_x,
  input  logic [7:0]          spr_y,
  input  logic [1:0]          spr_id,
  output logic                spr_ack,
  output logic [14:0]         bg_addr,
  input  logic [COLOUR_W-1:0] bg_q,
  output logic [9:0]          spr_addr,
  input  logic [COLOUR_W-1:0] spr_q,
  output logic [7:0]          oX,
  output logic [7:0]          oY,
  output logic [COLOUR_W-1:0] oColour,
  output logic                oPlot,
  output logic                busy,
  output logic                done
);

  localparam int   SPR_AREA   = SPR_SIZE * SPR_SIZE;
  localparam int   ID_W       = $clog2(SPR_COUNT);
  localparam logic DRAIN_LAST = 1'(DRAIN_CYCLES - 1);
`ifdef PLOT_SCHED_TRANSPARENCY_EN
  localparam logic KEY_EN     = 1'b1;
`else
  localparam logic KEY_EN     = 1'b0;
`endif

  // Control
  state_e              state_q, state_d;
  logic                drain_q, drain_d;
  logic                can_accept_s, accept_bg_s, accept_spr_s, advance_s;
  logic                run_s, spr_run_s;
  // Walker
  logic [COORD_W-1:0]  walk_col_s, walk_row_s;
  logic                walk_last_s;
  logic [COORD_W-1:0]  walk_w_s, walk_h_s;
  // Latched sprite request and ROM addresses
  logic [7:0]          sx_q, sx_d, sy_q, sy_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [14:0]         bg_addr_q, bg_addr_d;
  logic [9:0]          spr_addr_q, spr_addr_d;
  // Stage 1
  logic                s1_valid_q, s1_valid_d, s1_spr_q, s1_spr_d, s1_last_q, s1_last_d;
  logic [8:0]          s1_x_q, s1_x_d, s1_y_q, s1_y_d;
  // Stage 2 / outputs
  logic [COLOUR_W-1:0] colour_s;
  logic                key_s;
  logic [7:0]          ox_q, ox_d, oy_q, oy_d;
  logic [COLOUR_W-1:0] oc_q, oc_d;
  logic                plot_q, plot_d, done_q, done_d, busy_q, busy_d;
  logic                bg_ack_q, bg_ack_d, spr_ack_q, spr_ack_d;

  assign walk_w_s = accept_bg_s ? 8'(SCREEN_W) : 8'(SPR_SIZE);
  assign walk_h_s = accept_bg_s ? 8'(SCREEN_H) : 8'(SPR_SIZE);

  pixel_walker u_walker (
    .clk     (clk),
    .reset   (reset),
    .load    (accept_bg_s || accept_spr_s),
    .width   (walk_w_s),
    .height  (walk_h_s),
    .advance (advance_s),
    .col     (walk_col_s),
    .row     (walk_row_s),
    .last    (walk_last_s)
  );

  // Scheduler FSM: arbitration, run, and a fixed drain; the last drain cycle
  // may accept directly so the next ack lands the cycle after done.
  always_comb begin
    state_d      = state_q;
    drain_d      = drain_q;
    can_accept_s = 1'b0;
    accept_bg_s  = 1'b0;
    accept_spr_s = 1'b0;
    advance_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        can_accept_s = 1'b1;
      end
      ST_BG_RUN, ST_SPR_RUN: begin
        advance_s = 1'b1;
        if (walk_last_s) begin
          state_d = ST_DRAIN;
          drain_d = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          can_accept_s = 1'b1;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (can_accept_s) begin
      if (bg_req) begin
        accept_bg_s = 1'b1;
        state_d     = ST_BG_RUN;
      end else if (spr_req) begin
        accept_spr_s = 1'b1;
        state_d      = ST_SPR_RUN;
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      accept_bg_s = 1'b0;
    end
  end

  // Datapath next values: address counters, request latch, two pipe stages.
  always_comb begin
    run_s     = (state_q == ST_BG_RUN) || (state_q == ST_SPR_RUN);
    spr_run_s = (state_q == ST_SPR_RUN);

    sx_d = sx_q;
    sy_d = sy_q;
    id_d = id_q;
    if (accept_bg_s || accept_spr_s) begin
      sx_d = spr_x;
      sy_d = spr_y;
      id_d = spr_id[ID_W-1:0];
    end else begin
      id_d = id_q;
    end

    // Both walks are row-major over contiguous ROM words, so a counter suffices.
    if (accept_bg_s) begin
      bg_addr_d = 15'd0;
    end else if (state_q == ST_BG_RUN) begin
      bg_addr_d = bg_addr_q + 15'd1;
    end else begin
      bg_addr_d = bg_addr_q;
    end
    if (accept_spr_s) begin
      spr_addr_d = 10'(int'(spr_id[ID_W-1:0]) * SPR_AREA);
    end else if (spr_run_s) begin
      spr_addr_d = spr_addr_q + 10'd1;
    end else begin
      spr_addr_d = spr_addr_q;
    end

    s1_valid_d = run_s;
    s1_spr_d   = spr_run_s;
    s1_last_d  = run_s && walk_last_s;
    if (spr_run_s) begin
      s1_x_d = {1'b0, sx_q} + {1'b0, walk_col_s};
      s1_y_d = {1'b0, sy_q} + {1'b0, walk_row_s};
    end else begin
      s1_x_d = {1'b0, walk_col_s};
      s1_y_d = {1'b0, walk_row_s};
    end

    colour_s = s1_spr_q ? spr_q : bg_q;
    key_s    = KEY_EN && s1_spr_q && (spr_q == KEY_COLOUR);
    plot_d   = s1_valid_q && in_screen(s1_x_q, s1_y_q, SCREEN_W, SCREEN_H) && !key_s;
    if (plot_d) begin
      ox_d = s1_x_q[7:0];
      oy_d = s1_y_q[7:0];
      oc_d = colour_s;
    end else begin
      ox_d = ox_q;
      oy_d = oy_q;
      oc_d = oc_q;
    end
    done_d    = s1_valid_q && s1_last_q;
    busy_d    = (state_d != ST_IDLE);
    bg_ack_d  = accept_bg_s;
    spr_ack_d = accept_spr_s;
  end

  // All state and output registers; reset discards any blit in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      drain_q    <= 1'b0;
      sx_q       <= 8'd0;
      sy_q       <= 8'd0;
      id_q       <= '0;
      bg_addr_q  <= 15'd0;
      spr_addr_q <= 10'd0;
      s1_valid_q <= 1'b0;
      s1_spr_q   <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_x_q     <= 9'd0;
      s1_y_q     <= 9'd0;
      ox_q       <= 8'd0;
      oy_q       <= 8'd0;
      oc_q       <= '0;
      plot_q     <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      bg_ack_q   <= 1'b0;
      spr_ack_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      drain_q    <= drain_d;
      sx_q       <= sx_d;
      sy_q       <= sy_d;
      id_q       <= id_d;
      bg_addr_q  <= bg_addr_d;
      spr_addr_q <= spr_addr_d;
      s1_valid_q <= s1_valid_d;
      s1_spr_q   <= s1_spr_d;
      s1_last_q  <= s1_last_d;
      s1_x_q     <= s1_x_d;
      s1_y_q     <= s1_y_d;
      ox_q       <= ox_d;
      oy_q       <= oy_d;
      oc_q       <= oc_d;
      plot_q     <= plot_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      bg_ack_q   <= bg_ack_d;
      spr_ack_q  <= spr_ack_d;
    end
  end

  assign bg_ack   = bg_ack_q;
  assign spr_ack  = spr_ack_q;
  assign bg_addr  = bg_addr_q;
  assign spr_addr = spr_addr_q;
  assign oX       = ox_q;
  assign oY       = oy_q;
  assign oColour  = oc_q;
  assign oPlot    = plot_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_plot_scheduler.sv
// tb_plot_scheduler: table of blit scenarios with hand-computed plot counts
// and first addresses, a per-cycle pixel model, plus hand-written sequences
// for arbitration and mid-blit reset.
module tb_plot_scheduler;

  localparam int          W   = 160;
  localparam int          H   = 120;
  localparam logic [11:0] KEY = 12'hF0F;
`ifdef PLOT_SCHED_TRANSPARENCY_EN
  localparam bit TRANSP = 1'b1;
`else
  localparam bit TRANSP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        bg_req = 1'b0, spr_req = 1'b0;
  logic [7:0]  spr_x = 8'd0, spr_y = 8'd0;
  logic [1:0]  spr_id = 2'd0;
  logic        bg_ack, spr_ack, oPlot, busy, done;
  logic [14:0] bg_addr;
  logic [9:0]  spr_addr;
  logic [11:0] bg_q = 12'd0, spr_q = 12'd0;
  logic [7:0]  oX, oY;
  logic [11:0] oColour;
  bit          key_mode = 1'b0;

  int checks = 0;
  int failures = 0;
  logic [7:0]  sh_x = 8'd0, sh_y = 8'd0;
  logic [11:0] sh_c = 12'd0;

  plot_scheduler dut (
    .clk(clk), .reset(reset), .bg_req(bg_req), .bg_ack(bg_ack),
    .spr_req(spr_req), .spr_x(spr_x), .spr_y(spr_y), .spr_id(spr_id),
    .spr_ack(spr_ack), .bg_addr(bg_addr), .bg_q(bg_q), .spr_addr(spr_addr),
    .spr_q(spr_q), .oX(oX), .oY(oY), .oColour(oColour), .oPlot(oPlot),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] bgc(input logic [14:0] a);
    logic [31:0] t;
    t = 32'(a) * 32'd37 + 32'd11;
    return t[11:0];
  endfunction

  function automatic logic [11:0] sprc(input logic [9:0] a, input bit km);
    logic [31:0] t;
    if (km && !a[0]) return KEY;
    t = 32'(a) * 32'd5 + 32'd1;
    return t[11:0];
  endfunction

  // ROM models with one cycle of read latency.
  always @(posedge clk) begin
    bg_q  <= bgc(bg_addr);
    spr_q <= sprc(spr_addr, key_mode);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at the negedge of the ack cycle A; follows cycles A+1..A+N+1.
  task automatic run_blit(input bit is_bg, input int sx, input int sy, input int id,
                          input bit km, output int plots, output int errs, output int done_k);
    int n, i, x, y, a;
    bit ep;
    logic [11:0] c;
    n = is_bg ? W * H : 256;
    plots = 0; errs = 0; done_k = -1;
    for (int k = 1; k <= n + 1; k++) begin
      @(negedge clk);
      ep = 1'b0; c = 12'd0; x = 0; y = 0;
      if (k >= 2) begin
        i = k - 2;
        if (is_bg) begin
          x = i % W; y = i / W; c = bgc(15'(i)); ep = 1'b1;
        end else begin
          x = sx + i % 16; y = sy + i / 16;
          a = id * 256 + (i / 16) * 16 + i % 16;
          c = sprc(10'(a), km);
          ep = (x < W) && (y < H) && !(TRANSP && c == KEY);
        end
      end
      if (busy !== 1'b1 || bg_ack !== 1'b0 || spr_ack !== 1'b0) errs++;
      if (oPlot !== ep) errs++;
      if (oPlot === 1'b1) plots++;
      if (ep) begin
        if (oX !== 8'(x) || oY !== 8'(y) || oColour !== c) errs++;
        sh_x = 8'(x); sh_y = 8'(y); sh_c = c;
      end else begin
        if (oX !== sh_x || oY !== sh_y || oColour !== sh_c) errs++;
      end
      if (done !== (k == n + 1)) errs++;
      if (done === 1'b1 && done_k < 0) done_k = k;
    end
  endtask

  typedef struct {
    bit is_bg; int sx; int sy; int id; bit keyed; int exp_plots; int exp_addr;
  } vec_t;
  vec_t vecs[5];

  initial begin
    int plots, errs, done_k, waited, n;
    bit got;
    vecs[0] = '{1'b1,   0,   0, 0, 1'b0, 19200,   0};
    vecs[1] = '{1'b0,  40,  30, 2, 1'b0,   256, 512};
    vecs[2] = '{1'b0, 150, 112, 1, 1'b0,    80, 256};
    vecs[3] = '{1'b0,   0,   0, 0, 1'b0,   256,   0};
    vecs[4] = '{1'b0,  10,   5, 3, 1'b1, TRANSP ? 128 : 256, 768};

    repeat (3) @(negedge clk);
    chk("rst_plot", oPlot, 1'b0);
    chk("rst_busy_done", {busy, done}, 2'b00);
    chk("rst_acks", {bg_ack, spr_ack}, 2'b00);
    chk("rst_pixel", {oX, oY, oColour}, 28'd0);
    chk("rst_addr", {bg_addr, spr_addr}, 25'd0);
    reset = 1'b0;

    for (int v = 0; v < 5; v++) begin
      n = vecs[v].is_bg ? W * H : 256;
      spr_x = 8'(vecs[v].sx); spr_y = 8'(vecs[v].sy); spr_id = 2'(vecs[v].id);
      key_mode = vecs[v].keyed;
      bg_req = vecs[v].is_bg; spr_req = !vecs[v].is_bg;
      got = 1'b0; waited = 0;
      while (!got && waited < 50) begin
        @(negedge clk);
        waited++;
        if (bg_ack === 1'b1 || spr_ack === 1'b1) got = 1'b1;
      end
      chk("ack_latency", waited, 1);
      if (got) begin
        chk("ack_kind", {bg_ack, spr_ack}, vecs[v].is_bg ? 2'b10 : 2'b01);
        chk("first_addr", vecs[v].is_bg ? 32'(bg_addr) : 32'(spr_addr), vecs[v].exp_addr);
        chk("busy_at_ack", busy, 1'b1);
        bg_req = 1'b0; spr_req = 1'b0;
        run_blit(vecs[v].is_bg, vecs[v].sx, vecs[v].sy, vecs[v].id, vecs[v].keyed,
                 plots, errs, done_k);
        chk("plot_count", plots, vecs[v].exp_plots);
        chk("pixel_errs", errs, 0);
        chk("done_cycle", done_k, n + 1);
        @(negedge clk);
        chk("idle_after", {busy, done, oPlot}, 3'b000);
      end else begin
        bg_req = 1'b0; spr_req = 1'b0;
      end
    end

    // Simultaneous requests: background first, sprite acked the cycle after done.
    key_mode = 1'b0;
    spr_x = 8'd60; spr_y = 8'd50; spr_id = 2'd1;
    bg_req = 1'b1; spr_req = 1'b1;
    @(negedge clk);
    chk("simul_bg_first", {bg_ack, spr_ack}, 2'b10);
    bg_req = 1'b0;
    run_blit(1'b1, 0, 0, 0, 1'b0, plots, errs, done_k);
    chk("simul_bg_errs", errs, 0);
    @(negedge clk);
    chk("simul_spr_next", {bg_ack, spr_ack}, 2'b01);
    chk("simul_spr_addr", spr_addr, 10'd256);
    spr_req = 1'b0;
    run_blit(1'b0, 60, 50, 1, 1'b0, plots, errs, done_k);
    chk("simul_spr_plots", plots, 256);
    chk("simul_spr_errs", errs, 0);

    // Reset at pixel 100 of a background blit with bg_req held throughout.
    @(negedge clk);
    bg_req = 1'b1;
    @(negedge clk);
    chk("mid_ack", bg_ack, 1'b1);
    repeat (102) @(negedge clk);
    chk("mid_pixel100", {oPlot, oX, oY}, {1'b1, 8'd100, 8'd0});
    reset = 1'b1;
    @(negedge clk);
    chk("mid_reset_quiet", {oPlot, busy, done, bg_ack}, 4'b0000);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_reack", bg_ack, 1'b1);
    bg_req = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
